// File: rtl/issue_scoreboard_if.sv
// Bundle of the instruction-buffer, writeback and issue-output channels of issue_scoreboard.
// The slave modport is the scoreboard side; the master modport is the surrounding pipeline.
interface issue_scoreboard_if #(
  parameter int PER_ISSUE_WARPS = 4,
  parameter int NUM_REGS        = 64,
  parameter int META_W          = 64
);
  localparam int WIS_W   = (PER_ISSUE_WARPS > 1) ? $clog2(PER_ISSUE_WARPS) : 1;
  localparam int NR_BITS = $clog2(NUM_REGS);

  logic [PER_ISSUE_WARPS-1:0]              ibuf_valid;
  logic [PER_ISSUE_WARPS-1:0]              ibuf_ready;
  logic [PER_ISSUE_WARPS-1:0]              ibuf_wb;
  logic [PER_ISSUE_WARPS-1:0][NR_BITS-1:0] ibuf_rd;
  logic [PER_ISSUE_WARPS-1:0][NR_BITS-1:0] ibuf_rs1;
  logic [PER_ISSUE_WARPS-1:0][NR_BITS-1:0] ibuf_rs2;
  logic [PER_ISSUE_WARPS-1:0][NR_BITS-1:0] ibuf_rs3;
  logic [PER_ISSUE_WARPS-1:0][META_W-1:0]  ibuf_meta;

  logic               wb_valid;
  logic [WIS_W-1:0]   wb_wis;
  logic [NR_BITS-1:0] wb_rd;
  logic               wb_eop;

  logic               sb_valid;
  logic               sb_ready;
  logic [WIS_W-1:0]   sb_wis;
  logic               sb_wb;
  logic [NR_BITS-1:0] sb_rd;
  logic [NR_BITS-1:0] sb_rs1;
  logic [NR_BITS-1:0] sb_rs2;
  logic [NR_BITS-1:0] sb_rs3;
  logic [META_W-1:0]  sb_meta;

  modport master (
    output ibuf_valid, ibuf_wb, ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3, ibuf_meta,
    output wb_valid, wb_wis, wb_rd, wb_eop,
    output sb_ready,
    input  ibuf_ready,
    input  sb_valid, sb_wis, sb_wb, sb_rd, sb_rs1, sb_rs2, sb_rs3, sb_meta
  );

  modport slave (
    input  ibuf_valid, ibuf_wb, ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3, ibuf_meta,
    input  wb_valid, wb_wis, wb_rd, wb_eop,
    input  sb_ready,
    output ibuf_ready,
    output sb_valid, sb_wis, sb_wb, sb_rd, sb_rs1, sb_rs2, sb_rs3, sb_meta
  );
endinterface

// File: rtl/issue_scoreboard.sv
// Per-warp register scoreboard with round-robin issue into a registered valid/ready output.
// Optional SCOREBOARD_PERF_EN adds a saturating 44-bit count of structural-hazard-free stall cycles.
module issue_scoreboard #(
  parameter int PER_ISSUE_WARPS = 4,
  parameter int NUM_REGS        = 64,
  parameter int META_W          = 64
) (
  input  logic               clk,
  input  logic               reset,
  issue_scoreboard_if.slave  bus
`ifdef SCOREBOARD_PERF_EN
  ,
  output logic [43:0]        perf_stalls
`endif
);

  localparam int WIS_W   = (PER_ISSUE_WARPS > 1) ? $clog2(PER_ISSUE_WARPS) : 1;
  localparam int NR_BITS = $clog2(NUM_REGS);

  typedef struct packed {
    logic [WIS_W-1:0]   wis;
    logic               wb;
    logic [NR_BITS-1:0] rd;
    logic [NR_BITS-1:0] rs1;
    logic [NR_BITS-1:0] rs2;
    logic [NR_BITS-1:0] rs3;
    logic [META_W-1:0]  meta;
  } issue_t;

  logic [PER_ISSUE_WARPS-1:0][NUM_REGS-1:0] inuse_q, inuse_d;
  issue_t                                   out_q, out_d;
  logic                                     sb_valid_q, sb_valid_d;
  logic [WIS_W-1:0]                         rr_ptr_q, rr_ptr_d;

  logic [PER_ISSUE_WARPS-1:0] hazard;
  logic [PER_ISSUE_WARPS-1:0] eligible;
  logic [PER_ISSUE_WARPS-1:0] grant;
  logic [WIS_W-1:0]           winner;
  logic [WIS_W-1:0]           scan_idx;
  logic                       any_eligible;
  logic                       out_free;
  logic                       accept;

  // RAW on any source and WAW on rd stall; a pending write to rd is not a
  // hazard when the instruction itself does not write rd.
  // NOTE: every always_comb output gets a default on entry so no path leaves it unassigned (no latch).
  always_comb begin
    hazard   = '0;
    eligible = '0;
    for (int w = 0; w < PER_ISSUE_WARPS; w++) begin
      hazard[w] = inuse_q[w][bus.ibuf_rs1[w]]
                | inuse_q[w][bus.ibuf_rs2[w]]
                | inuse_q[w][bus.ibuf_rs3[w]]
                | (bus.ibuf_wb[w] & inuse_q[w][bus.ibuf_rd[w]]);
      eligible[w] = bus.ibuf_valid[w] & ~hazard[w];
    end
  end

  // Scan downwards so the lowest offset from the pointer is the final winner.
  always_comb begin
    winner       = '0;
    scan_idx     = '0;
    any_eligible = 1'b0;
    for (int i = PER_ISSUE_WARPS - 1; i >= 0; i--) begin
      scan_idx = rr_ptr_q + WIS_W'(i);
      if (eligible[scan_idx]) begin
        winner       = scan_idx;
        any_eligible = 1'b1;
      end
    end
  end

  assign out_free = ~sb_valid_q | bus.sb_ready;
  assign accept   = out_free & any_eligible & ~reset;

  always_comb begin
    grant = '0;
    if (accept) grant[winner] = 1'b1;
  end

  assign bus.ibuf_ready = grant;

  // Clear first, then set, so a same-bit set in the same cycle wins.
  always_comb begin
    inuse_d = inuse_q;
    if (bus.wb_valid && bus.wb_eop) begin
      inuse_d[bus.wb_wis][bus.wb_rd] = 1'b0;
    end
    if (accept && bus.ibuf_wb[winner] && (bus.ibuf_rd[winner] != '0)) begin
      inuse_d[winner][bus.ibuf_rd[winner]] = 1'b1;
    end
  end

  always_comb begin
    out_d      = out_q;
    sb_valid_d = sb_valid_q;
    rr_ptr_d   = rr_ptr_q;
    if (accept) begin
      out_d.wis  = winner;
      out_d.wb   = bus.ibuf_wb[winner];
      out_d.rd   = bus.ibuf_rd[winner];
      out_d.rs1  = bus.ibuf_rs1[winner];
      out_d.rs2  = bus.ibuf_rs2[winner];
      out_d.rs3  = bus.ibuf_rs3[winner];
      out_d.meta = bus.ibuf_meta[winner];
      sb_valid_d = 1'b1;
      rr_ptr_d   = (PER_ISSUE_WARPS == 1) ? '0 : winner + WIS_W'(1);
    end else if (bus.sb_ready) begin
      sb_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the inuse bitmap is reset explicitly; stale pending bits after reset would deadlock issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      inuse_q    <= '0;
      out_q      <= '0;
      sb_valid_q <= 1'b0;
      rr_ptr_q   <= '0;
    end else begin
      inuse_q    <= inuse_d;
      out_q      <= out_d;
      sb_valid_q <= sb_valid_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign bus.sb_valid = sb_valid_q;
  assign bus.sb_wis   = out_q.wis;
  assign bus.sb_wb    = out_q.wb;
  assign bus.sb_rd    = out_q.rd;
  assign bus.sb_rs1   = out_q.rs1;
  assign bus.sb_rs2   = out_q.rs2;
  assign bus.sb_rs3   = out_q.rs3;
  assign bus.sb_meta  = out_q.meta;

`ifdef SCOREBOARD_PERF_EN
  // Counts cycles where work is waiting, the output could take it, yet every warp is hazarded.
  logic [43:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if ((|bus.ibuf_valid) && out_free && !any_eligible && !(&perf_q)) begin
      perf_d = perf_q + 44'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign perf_stalls = perf_q;
`endif

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

Issue-stage register scoreboard sitting directly upstream of the operand-collection stage. It takes decoded instructions from the per-warp instruction buffers and tracks, per warp, which destination registers have writes in flight. A round-robin arbiter selects one hazard-free warp per cycle and presents it on a registered valid/ready output that feeds operand collection. Writeback completions clear the pending bits.

## Interface
Parameters:
- PER_ISSUE_WARPS, 4: warps served by this issue slice (power of 2, ≥1); WIS_W = max(1, clog2(PER_ISSUE_WARPS)).
- NUM_REGS, 64: architectural registers per warp; NR_BITS = clog2(NUM_REGS).
- META_W, 64: opaque per-instruction payload (tmask, PC, ex/op type, args, uuid), passed through untouched.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high.
- ibuf_valid  in  PER_ISSUE_WARPS  instruction available, per warp.
- ibuf_ready  out  PER_ISSUE_WARPS  instruction taken from warp w this cycle.
- ibuf_wb  in  PER_ISSUE_WARPS  instruction writes rd.
- ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3  in  PER_ISSUE_WARPS×NR_BITS each  register indices.
- ibuf_meta  in  PER_ISSUE_WARPS×META_W  payload.
- wb_valid  in  1  writeback beat.
- wb_wis  in  WIS_W  warp of writeback.
- wb_rd  in  NR_BITS  register written.
- wb_eop  in  1  last beat of that writeback.
- sb_valid  out  1  issued instruction valid.
- sb_ready  in  1  downstream accepts.
- sb_wis, sb_wb, sb_rd, sb_rs1, sb_rs2, sb_rs3, sb_meta  out  registered copy of the issued instruction.

## Operation
- State: inuse[PER_ISSUE_WARPS][NUM_REGS] bitmap; round-robin pointer (WIS_W bits); output register + valid bit.
- Register 0 is never tracked: inuse[w][0] reads as 0; a set to rd=0 is discarded.
- Warp w eligible iff ibuf_valid[w] and none of rs1, rs2, rs3 and (rd if ibuf_wb[w]) is inuse in warp w (WAR on rd ignored; RAW and WAW stall).
- Accept condition: out_free = ~sb_valid | sb_ready. When out_free and any warp eligible, round-robin picks the first eligible warp at or after the pointer; ibuf_ready asserted one-hot for that warp only; output register loads its fields; pointer moves to winner+1 (mod PER_ISSUE_WARPS).
- ibuf_ready is zero for all warps when out_free is 0 or no warp eligible; ibuf_ready never depends on ibuf_valid of the same warp beyond eligibility (no combinational loop via sb_ready is permitted other than out_free).
- On accept with wb=1 and rd≠0: inuse[winner][rd] ← 1.
- On wb_valid & wb_eop: inuse[wb_wis][wb_rd] ← 0. Non-eop beats do nothing.
- Set and clear to the same bit in the same cycle: set wins. Clear and set to different bits: both apply.
- Clearing is visible to eligibility the following cycle (no same-cycle bypass).
- Output holds stable while sb_valid & ~sb_ready.

## Timing
- Latency: accepted at edge N, sb_valid high from cycle N+1.
- Throughput: one instruction per cycle while sb_ready held high.
- Back-to-back dependent instruction from same warp: stalls until cycle after its producer's wb_eop.
- Reset: sb_valid=0, all inuse=0, pointer=0, ibuf_ready=0; output data fields reset to 0. Reset mid-operation discards the held output and all pending bits.

## Configuration
- SCOREBOARD_PERF_EN defined: adds output perf_stalls [43:0], incremented each cycle where some ibuf_valid is set, out_free is 1, and no warp is eligible; reset to 0; saturates at all-ones.
- Not defined: port absent, no counter logic.

## Test plan
- Reset then warp 0 issues rd=5 wb=1, sb_ready=1 -> sb_valid next cycle with sb_rd=5; inuse[0][5]=1.
- Warp 0 next reads rs1=5 -> held (ibuf_ready[0]=0) until wb_valid,wb_wis=0,wb_rd=5,wb_eop=1; issued the cycle after; non-eop beat alone leaves it stalled.
- All 4 warps valid, independent, sb_ready=1 -> issue order 0,1,2,3,0 one per cycle.
- sb_ready=0 for 3 cycles with sb_valid=1 -> outputs stable, ibuf_ready all 0; release -> next instruction one cycle later.
- rd=0 wb=1 repeatedly from warp 2 -> never stalls, inuse[2][0] stays 0.
- With SCOREBOARD_PERF_EN: warp 1 stalled on RAW for 7 cycles, others idle -> perf_stalls=7.
